mc_control_fsm: RTL
===================

Name: mc_control_fsm

Overview:
- Multicycle RV32I control unit. Sequences a shared-memory datapath (single instruction/data memory port, IR, OldPC, ALUOut and Data registers) through the fetch, decode, execute, memory and writeback steps.
- Supports lw, sw, R-type, I-type ALU, beq/bne and jal.
- Stalls on a memory-ready handshake and detects memory timeouts and illegal opcodes.
- Sits beside the datapath in place of the single-cycle control path.

Parameters:
- MEM_TIMEOUT, 255: cycles a memory access may wait for MemReady before a fault; legal range 1..1023.
- CNT_W, 10: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  clock; rising-edge.
- reset  in  1  asynchronous, active-high.
- Instr  in  32  IR contents; opcode [6:0], funct3 [14:12], funct7b5 [30].
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory completes the current read or write this cycle.
- PCWrite  out  1  PC load enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  IR and OldPC load enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
- ALUSrcB  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- ALU_Control  out  4  ALU operation.
- instr_retire  out  1  one-cycle pulse when an instruction completes.
- illegal_instr  out  1  sticky flag: unsupported opcode was decoded.
- mem_fault  out  1  sticky flag: memory access timed out.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, FAULT.
- Reset (asynchronous): state = FETCH; wait counter = 0; illegal_instr = mem_fault = 0.
  - While reset is high, all enables (PCWrite, MemWrite, IRWrite, RegWrite) and instr_retire are 0.
  - Mux selects are don't-care but drive 0.
- All outputs are combinational from state, Instr, Zero and MemReady. Unlisted outputs are 0.
- Opcodes: lw 0000011, sw 0100011, R-type 0110011, I-type ALU 0010011, branch 1100011, jal 1101111.
- ImmSrc is decoded from the opcode in every state: lw and I-type -> 00, sw -> 01, branch -> 10, jal -> 11, other -> 00.
- ALUOp is internal: 00 = add, 01 = sub/compare, 10 = decode funct fields.
- ALU_Control comes from ALUOp, funct3, funct7b5 and opb5 (Instr[5]). Rules: add 0000, sub 0001, and 0010, or 0011, slt 0101; funct7b5 selects sub only when opb5 = 1.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - While MemReady=0: IRWrite=PCWrite=0 and the state holds.
  - When MemReady=1: IRWrite=1, PCWrite=1, next state DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - lw or sw -> MEMADR
  - R-type -> EXECR
  - I-type ALU -> EXECI
  - branch -> BRANCH
  - jal -> JAL
  - any other opcode -> FAULT, setting illegal_instr.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds until MemReady=1, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, retire; next state FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 for every cycle until MemReady=1; then retire and go to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10; next state ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire; next state FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, retire; next state FETCH.
  - PCWrite = Zero when funct3=000 (beq).
  - PCWrite = ~Zero when funct3=001 (bne).
  - Any other funct3 -> FAULT with illegal_instr set; no retire.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1; next state ALUWB.
- Wait counter:
  - Increments each cycle spent in FETCH, MEMREAD or MEMWRITE with MemReady=0.
  - Clears on any state change.
  - If the counter equals MEM_TIMEOUT-1 and MemReady=0: next state FAULT and mem_fault is set.
  - MemReady=1 on that same cycle wins: normal transition, no fault.
- FAULT: all enables 0. Exited only by reset. The sticky flags clear only on reset.
- Latency with MemReady=1 every cycle:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type and I-type: 4 cycles
  - branch: 3 cycles
  - jal: 4 cycles
- Reset asserted mid-instruction returns to FETCH immediately. No partial writes occur after the reset edge.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - the state enum
  - opcode constants
  - ALUOp and ALU_Control encodings
  - ResultSrc, ALUSrcA, ALUSrcB and ImmSrc encodings
- One sub-module: the existing ALUDecoder, instantiated for ALU_Control.
- The FSM, wait counter and ImmSrc decode stay in this block.

Test Plan:
- lw with MemReady=1 constantly -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 in cycle 5; instr_retire pulses once.
- sw with MemReady low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles; retire on the MemReady cycle; no RegWrite.
- beq with Zero=1 and bne (0x00209463) with Zero=1 -> PCWrite=1 in BRANCH for beq, PCWrite=0 for bne; both return to FETCH.
- add (funct7b5=0) vs sub (0x40208033) -> ALU_Control 0000 vs 0001 in EXECR; addi with Instr[30]=1 -> 0000.
- Opcode 0x7F in DECODE -> FAULT, illegal_instr=1; MemReady toggling thereafter causes no enables; reset clears the flag and state returns to FETCH.
- MEM_TIMEOUT=4 with MemReady held 0 in FETCH -> FAULT entered after exactly 4 FETCH cycles, mem_fault=1; a variant with MemReady=1 on the 4th cycle -> DECODE, no fault.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control unit.
// Holds the FSM state enum, the supported opcodes, the internal ALUOp
// encoding, the ALU_Control operation codes and the datapath mux-select
// encodings (ResultSrc, ALUSrcA, ALUSrcB, ImmSrc), plus the opcode-based
// immediate-format decode used in every state.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_FAULT
    } state_t;

    // Supported opcodes (Instr[6:0])
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Branch funct3 values
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // Internal ALU operation class
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    // ALU_Control operation codes
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0101;

    // ResultSrc
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALUSrcA
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    // ALUSrcB
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ImmSrc
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format depends only on the opcode; unsupported opcodes
    // fall back to the I format.
    function automatic logic [1:0] imm_src_of(input logic [6:0] opcode);
        case (opcode)
            OP_LW, OP_ITYPE: imm_src_of = IMM_I;
            OP_SW:           imm_src_of = IMM_S;
            OP_BRANCH:       imm_src_of = IMM_B;
            OP_JAL:          imm_src_of = IMM_J;
            default:         imm_src_of = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps the FSM's ALU operation class plus the instruction's
// funct fields to the 4-bit ALU_Control code.
// Ports:
//   alu_op      - operation class from the FSM (add / sub / decode funct)
//   funct3      - Instr[14:12]
//   funct7b5    - Instr[30]
//   opb5        - Instr[5]; distinguishes R-type (1) from I-type ALU (0)
//   alu_control - ALU operation code
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       opb5,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Instr[30] means sub only for R-type; for addi it is
                    // just an immediate bit.
                    3'b000:  alu_control = (funct7b5 && opb5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control unit. Steps a shared-memory datapath through
// fetch, decode, execute, memory and writeback for lw, sw, R-type,
// I-type ALU, beq/bne and jal. Memory accesses stall on MemReady and are
// bounded by a wait counter; a timeout or an unsupported instruction parks
// the FSM in FAULT until reset and raises a sticky flag.
// Ports:
//   clk, reset      - rising-edge clock, asynchronous active-high reset
//   Instr           - IR contents (opcode, funct3, funct7b5 used)
//   Zero            - ALU zero flag, used by beq/bne
//   MemReady        - memory completes the current access this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite - datapath enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALU_Control - datapath mux/ALU codes
//   instr_retire    - one-cycle pulse when an instruction completes
//   illegal_instr   - sticky: unsupported opcode / branch funct3 seen
//   mem_fault       - sticky: a memory access exceeded MEM_TIMEOUT cycles
module mc_control_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [3:0]  ALU_Control,
    output logic        instr_retire,
    output logic        illegal_instr,
    output logic        mem_fault
);

    // Last counter value before a stalled access is declared dead.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state;
    state_t           state_next;
    alu_op_t          alu_op;
    logic [CNT_W-1:0] wait_cnt;
    logic             waiting;
    logic             set_illegal;
    logic             set_mem_fault;

    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode = Instr[6:0];
    assign funct3 = Instr[14:12];

    // Instruction bits this block never looks at (register and immediate fields).
    logic unused_instr_bits;
    assign unused_instr_bits = ^{Instr[31], Instr[29:15], Instr[11:7]};

    // Next-state and output decode.
    // NOTE: every signal driven here gets a default first, so no path
    // through the case statements can leave one unassigned and infer a latch.
    always_comb begin
        state_next    = state;
        alu_op        = ALUOP_ADD;
        waiting       = 1'b0;
        set_illegal   = 1'b0;
        set_mem_fault = 1'b0;
        PCWrite       = 1'b0;
        AdrSrc        = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_RD2;
        ImmSrc        = imm_src_of(opcode);
        instr_retire  = 1'b0;

        case (state)
            S_FETCH: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                waiting   = !MemReady;
                if (MemReady) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target computed here and parked in ALUOut.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECR;
                    OP_ITYPE:     state_next = S_EXECI;
                    OP_BRANCH:    state_next = S_BRANCH;
                    OP_JAL:       state_next = S_JAL;
                    default: begin
                        state_next  = S_FAULT;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                state_next = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc    = 1'b1;
                ResultSrc = RES_ALUOUT;
                waiting   = !MemReady;
                if (MemReady) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc    = RES_DATA;
                RegWrite     = 1'b1;
                instr_retire = 1'b1;
                state_next   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                ResultSrc = RES_ALUOUT;
                MemWrite  = 1'b1;
                waiting   = !MemReady;
                if (MemReady) begin
                    instr_retire = 1'b1;
                    state_next   = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_RD2;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc    = RES_ALUOUT;
                RegWrite     = 1'b1;
                instr_retire = 1'b1;
                state_next   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_RD2;
                alu_op    = ALUOP_SUB;
                ResultSrc = RES_ALUOUT;
                case (funct3)
                    F3_BEQ: begin
                        PCWrite      = Zero;
                        instr_retire = 1'b1;
                        state_next   = S_FETCH;
                    end
                    F3_BNE: begin
                        PCWrite      = !Zero;
                        instr_retire = 1'b1;
                        state_next   = S_FETCH;
                    end
                    default: begin
                        state_next  = S_FAULT;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_JAL: begin
                // PC <- target from ALUOut; ALU computes the link value OldPC+4.
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALUOUT;
                PCWrite    = 1'b1;
                state_next = S_ALUWB;
            end
            S_FAULT: begin
                state_next = S_FAULT;
            end
            default: begin
                state_next = S_FAULT;
            end
        endcase

        // A stalled access on its last allowed cycle gives up; MemReady in
        // that same cycle already cleared `waiting`, so it wins.
        if (waiting && (wait_cnt == TIMEOUT_LAST)) begin
            state_next    = S_FAULT;
            set_mem_fault = 1'b1;
        end

        // The state register already sits in FETCH during reset, which would
        // otherwise enable IRWrite/PCWrite on MemReady; hold everything low.
        if (reset) begin
            alu_op       = ALUOP_ADD;
            PCWrite      = 1'b0;
            AdrSrc       = 1'b0;
            MemWrite     = 1'b0;
            IRWrite      = 1'b0;
            RegWrite     = 1'b0;
            ResultSrc    = '0;
            ALUSrcA      = '0;
            ALUSrcB      = '0;
            ImmSrc       = '0;
            instr_retire = 1'b0;
        end
    end

    // NOTE: state and counters use non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_FETCH;
            wait_cnt      <= '0;
            illegal_instr <= 1'b0;
            mem_fault     <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            illegal_instr <= illegal_instr | set_illegal;
            mem_fault     <= mem_fault | set_mem_fault;
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (Instr[30]),
        .opb5        (Instr[5]),
        .alu_control (ALU_Control)
    );

endmodule
